// File: rtl/apb_wdt_gen2.sv
// apb_wdt_gen2: APB watchdog with integrated down-counter, prescaler, keyed feed/lock,
// windowed refresh and two-stage timeout (IRQ first, sticky reset request second).
module apb_wdt_gen2 #(
    parameter int          CNT_W = 32,
    parameter int          PRE_W = 8,
    parameter logic [31:0] KEY   = 32'h1ACCE551
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic [19:2] PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        IRQ,
    output logic        WDT_RST_REQ
);
    logic [CNT_W-1:0] cnt, load, win;
    logic [PRE_W-1:0] pre, psc;
    logic             en, rsten, winen, ov, winviol, rstreq, locked;
    logic [1:0]       irqen;
    logic             wr, cfg_wr, clr_wr, tick, feed_key, early, feed_ok, timeout, en_rise;

    assign wr       = PSEL & PWRITE & PENABLE;
    assign cfg_wr   = wr & ~locked;
    assign clr_wr   = wr & (PADDR == 18'h4);
    assign tick     = en & (psc == pre);
    assign feed_key = wr & (PADDR == 18'h6) & (PWDATA == KEY);
    assign early    = feed_key & winen & (cnt > win);
    assign feed_ok  = feed_key & ~early;
    // a valid feed landing on the zero tick pre-empts the timeout
    assign timeout  = tick & (cnt == '0) & ~feed_ok;
    assign en_rise  = cfg_wr & (PADDR == 18'h5) & PWDATA[0] & ~en;

    assign PREADY      = 1'b1;
    assign WDT_RST_REQ = rstreq;
    assign IRQ         = (ov & irqen[0]) | (winviol & irqen[1]);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt     <= '1;
            load    <= '0;
            win     <= '0;
            pre     <= '0;
            psc     <= '0;
            en      <= 1'b0;
            rsten   <= 1'b0;
            winen   <= 1'b0;
            irqen   <= '0;
            ov      <= 1'b0;
            winviol <= 1'b0;
            rstreq  <= 1'b0;
            locked  <= 1'b0;
        end else begin
            if (en_rise || feed_ok) begin
                cnt <= load;
                psc <= '0;
            end else if (en) begin
                psc <= tick ? '0 : psc + PRE_W'(1);
                if (tick) cnt <= (cnt == '0) ? load : cnt - CNT_W'(1);
            end
            ov      <= (timeout & ~ov) | (ov & ~(clr_wr & PWDATA[0]));
            winviol <= early | (winviol & ~(clr_wr & PWDATA[2]));
            rstreq  <= rstreq | (rsten & (early | (timeout & ov)));
            if (wr && PADDR == 18'h7) locked <= (PWDATA != KEY);
            if (cfg_wr && PADDR == 18'h1) load <= PWDATA[CNT_W-1:0];
            if (cfg_wr && PADDR == 18'h2) win <= PWDATA[CNT_W-1:0];
            if (cfg_wr && PADDR == 18'h5) begin
                en    <= PWDATA[0];
                rsten <= PWDATA[1];
                winen <= PWDATA[2];
                pre   <= PWDATA[8 +: PRE_W];
            end
            if (cfg_wr && PADDR == 18'h40) irqen <= PWDATA[1:0];
        end
    end

    always_comb begin
        case (PADDR)
            18'h0:               PRDATA = 32'(cnt);
            18'h1:               PRDATA = 32'(load);
            18'h2:               PRDATA = 32'(win);
            18'h3:               PRDATA = {28'd0, locked, winviol, rstreq, ov};
            18'h4, 18'h6, 18'h7: PRDATA = '0;
            18'h5:               PRDATA = 32'({pre, 5'd0, winen, rsten, en});
            18'h40:              PRDATA = {30'd0, irqen};
            default:             PRDATA = 32'hDEADBEEF;
        endcase
    end
endmodule

// File: tb/tb_apb_wdt_gen2.sv
// tb_apb_wdt_gen2: directed scenarios plus randomized APB traffic checked against
// a rule-level watchdog model.
module tb_apb_wdt_gen2;
    localparam logic [31:0] KEY = 32'h1ACCE551;

    logic        PCLK = 0, PRESETn = 0, PSEL = 0, PENABLE = 0, PWRITE = 0;
    logic [19:2] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, IRQ, WDT_RST_REQ;
    int          errors = 0, checks = 0;

    logic [31:0] m_cnt, m_load, m_win;
    logic [7:0]  m_pre;
    logic [1:0]  m_irqen;
    int          m_psc;
    bit          m_en, m_rsten, m_winen, m_ov, m_wv, m_rst, m_lock;

    apb_wdt_gen2 dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .IRQ(IRQ),
        .WDT_RST_REQ(WDT_RST_REQ)
    );

    always #5 PCLK = ~PCLK;

    // Reference model: applies the watchdog rules once per clock edge.
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            m_cnt = '1; m_load = 0; m_win = 0; m_pre = 0; m_psc = 0; m_irqen = 0;
            m_en = 0; m_rsten = 0; m_winen = 0; m_ov = 0; m_wv = 0; m_rst = 0; m_lock = 0;
        end else begin : step
            bit          wr, tick, feed, early, good, n_ov, n_wv;
            logic [31:0] n_cnt;
            int          n_psc;
            wr    = PSEL && PWRITE && PENABLE;
            tick  = m_en && (m_psc == m_pre);
            feed  = wr && PADDR == 6 && PWDATA == KEY;
            early = feed && m_winen && (m_cnt > m_win);
            good  = feed && !early;
            n_cnt = m_cnt;
            n_psc = m_en ? (tick ? 0 : m_psc + 1) : m_psc;
            n_ov  = m_ov;
            n_wv  = m_wv;
            if (wr && PADDR == 4 && PWDATA[0]) n_ov = 0;
            if (wr && PADDR == 4 && PWDATA[2]) n_wv = 0;
            if (tick && m_cnt != 0) n_cnt = m_cnt - 1;
            if (tick && m_cnt == 0) begin
                n_cnt = m_load;
                if (!good && !m_ov) n_ov = 1;
                else if (!good && m_rsten) m_rst = 1;
            end
            if (good) begin n_cnt = m_load; n_psc = 0; end
            if (early) begin n_wv = 1; if (m_rsten) m_rst = 1; end
            if (wr && !m_lock) begin
                if (PADDR == 5) begin
                    if (PWDATA[0] && !m_en) begin n_cnt = m_load; n_psc = 0; end
                    m_en = PWDATA[0]; m_rsten = PWDATA[1]; m_winen = PWDATA[2]; m_pre = PWDATA[15:8];
                end
                if (PADDR == 1) m_load = PWDATA;
                if (PADDR == 2) m_win = PWDATA;
                if (PADDR == 'h40) m_irqen = PWDATA[1:0];
            end
            if (wr && PADDR == 7) m_lock = (PWDATA != KEY);
            m_cnt = n_cnt; m_psc = n_psc; m_ov = n_ov; m_wv = n_wv;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [19:2] a);
        case (a)
            0:       return m_cnt;
            1:       return m_load;
            2:       return m_win;
            3:       return {28'd0, m_lock, m_wv, m_rst, m_ov};
            4, 6, 7: return 0;
            5:       return {16'd0, m_pre, 5'd0, m_winen, m_rsten, m_en};
            'h40:    return {30'd0, m_irqen};
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic apb_write(input logic [19:2] a, input logic [31:0] d);
        @(negedge PCLK);
        PADDR = a; PWDATA = d; PSEL = 1; PWRITE = 1; PENABLE = 0;
        @(negedge PCLK);
        PENABLE = 1;
        @(posedge PCLK);
        #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [19:2] a, output logic [31:0] d);
        PADDR = a; PSEL = 1; PWRITE = 0; PENABLE = 0;
        #1;
        d = PRDATA;
        PSEL = 0;
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        PRESETn = 0;
        @(posedge PCLK);
        #1;
        PRESETn = 1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        PRESETn = 0;
        repeat (2) @(posedge PCLK);
        #1;
        apb_read(0, v);
        checks++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_cnt got=%h exp=ffffffff", v); end
        apb_read(3, v);
        checks++; if (v !== 0) begin errors++; $display("FAIL reset_stat got=%h exp=0", v); end
        apb_read(5, v);
        checks++; if (v !== 0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", v); end
        apb_read(8, v);
        checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL unmapped got=%h exp=deadbeef", v); end
        apb_read(6, v);
        checks++; if (v !== 0) begin errors++; $display("FAIL feed_rd got=%h exp=0", v); end
        checks++; if (IRQ !== 0 || WDT_RST_REQ !== 0) begin errors++; $display("FAIL reset_out irq=%b rst=%b exp=0,0", IRQ, WDT_RST_REQ); end
        PRESETn = 1;
    endtask

    task automatic test_count();
        logic [31:0] v, e;
        apb_write(1, 5);
        apb_write(5, 32'h100);
        apb_write('h40, 1);
        apb_write(5, 32'h101);
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin @(posedge PCLK); #1; end
            apb_read(0, v);
            e = (k == 12) ? 32'd5 : 32'(5 - k / 2);
            checks++; if (v !== e) begin errors++; $display("FAIL count k=%0d got=%0d exp=%0d", k, v, e); end
            checks++; if (v !== m_cnt) begin errors++; $display("FAIL count_model k=%0d got=%0d exp=%0d", k, v, m_cnt); end
            checks++; if (IRQ !== (k == 12)) begin errors++; $display("FAIL irq k=%0d got=%b exp=%b", k, IRQ, k == 12); end
        end
    endtask

    task automatic test_rstreq();
        logic [31:0] v;
        apb_write(5, 32'h103);
        for (int k = 15; k <= 24; k++) begin
            @(posedge PCLK); #1;
            checks++; if (WDT_RST_REQ !== (k == 24)) begin errors++; $display("FAIL rstreq k=%0d got=%b exp=%b", k, WDT_RST_REQ, k == 24); end
        end
        apb_write(4, 5);
        apb_write(6, KEY);
        apb_write(5, 0);
        checks++; if (WDT_RST_REQ !== 1) begin errors++; $display("FAIL rstreq_sticky got=%b exp=1", WDT_RST_REQ); end
        apb_read(3, v);
        checks++; if (v[1] !== 1) begin errors++; $display("FAIL stat_rstreq got=%b exp=1", v[1]); end
        apb_write(5, 32'h101);
        @(negedge PCLK); #1;
        PRESETn = 0;
        #1;
        apb_read(0, v);
        checks++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL async_rst_cnt got=%h exp=ffffffff", v); end
        apb_read(3, v);
        checks++; if (v !== 0 || WDT_RST_REQ !== 0) begin errors++; $display("FAIL async_rst_stat got=%h rst=%b exp=0,0", v, WDT_RST_REQ); end
        @(posedge PCLK); #1;
        PRESETn = 1;
    endtask

    task automatic test_window();
        logic [31:0] v;
        int n;
        do_reset();
        apb_write(1, 100);
        apb_write(2, 20);
        apb_write(5, 32'h305);
        n = 0;
        do begin @(posedge PCLK); #1; apb_read(0, v); n++; end while (v > 50 && n < 2000);
        checks++; if (n >= 2000) begin errors++; $display("FAIL win_wait50 got=%0d exp<=50", v); end
        apb_write(6, KEY);
        apb_read(3, v);
        checks++; if (v !== 32'h4) begin errors++; $display("FAIL win_early_stat got=%h exp=4", v); end
        apb_read(0, v);
        checks++; if (v !== m_cnt || v == 100) begin errors++; $display("FAIL win_early_cnt got=%0d exp=%0d", v, m_cnt); end
        apb_write(4, 4);
        apb_read(3, v);
        checks++; if (v !== 0) begin errors++; $display("FAIL win_clr got=%h exp=0", v); end
        n = 0;
        do begin @(posedge PCLK); #1; apb_read(0, v); n++; end while (v > 10 && n < 2000);
        checks++; if (n >= 2000) begin errors++; $display("FAIL win_wait10 got=%0d exp<=10", v); end
        apb_write(6, KEY);
        apb_read(0, v);
        checks++; if (v !== 100) begin errors++; $display("FAIL win_feed got=%0d exp=100", v); end
        apb_read(3, v);
        checks++; if (v !== 0) begin errors++; $display("FAIL win_feed_stat got=%h exp=0", v); end
        repeat (12) @(posedge PCLK);
        apb_write(6, 0);
        apb_read(0, v);
        checks++; if (v !== m_cnt || v == 100) begin errors++; $display("FAIL bad_key got=%0d exp=%0d", v, m_cnt); end
    endtask

    task automatic test_lock();
        logic [31:0] v;
        apb_write(7, 0);
        apb_write(1, 7);
        apb_write(5, 0);
        apb_read(1, v);
        checks++; if (v !== 100) begin errors++; $display("FAIL locked_load got=%0d exp=100", v); end
        apb_read(3, v);
        checks++; if (v[3] !== 1) begin errors++; $display("FAIL locked_stat got=%b exp=1", v[3]); end
        apb_read(5, v);
        checks++; if (v !== 32'h305) begin errors++; $display("FAIL locked_ctrl got=%h exp=305", v); end
        apb_write(7, KEY);
        apb_write(1, 7);
        apb_read(1, v);
        checks++; if (v !== 7) begin errors++; $display("FAIL unlocked_load got=%0d exp=7", v); end
        apb_read(3, v);
        checks++; if (v[3] !== 0) begin errors++; $display("FAIL unlocked_stat got=%b exp=0", v[3]); end
    endtask

    task automatic test_collide();
        logic [31:0] v;
        do_reset();
        apb_write(1, 3);
        apb_write(5, 1);
        repeat (2) @(posedge PCLK);
        #1;
        apb_write(6, KEY);
        apb_read(0, v);
        checks++; if (v !== 3) begin errors++; $display("FAIL feed_vs_tick_cnt got=%0d exp=3", v); end
        apb_read(3, v);
        checks++; if (v !== 0) begin errors++; $display("FAIL feed_vs_tick_stat got=%h exp=0", v); end
        repeat (2) @(posedge PCLK);
        #1;
        apb_write(4, 1);
        apb_read(3, v);
        checks++; if (v !== 1) begin errors++; $display("FAIL clr_vs_set got=%h exp=1", v); end
        apb_write(4, 1);
        apb_read(3, v);
        checks++; if (v !== 0) begin errors++; $display("FAIL clr_ov got=%h exp=0", v); end
    endtask

    task automatic test_random();
        logic [31:0] v, d;
        logic [19:2] a;
        int sel;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 6);
            case (sel)
                0: begin a = 1; d = $urandom_range(0, 12); end
                1: begin a = 2; d = $urandom_range(0, 12); end
                2: begin a = 4; d = $urandom; end
                3: begin a = 5; d = ($urandom_range(0, 3) << 8) | $urandom_range(0, 7); end
                4: begin a = 6; d = ($urandom_range(0, 3) != 0) ? KEY : $urandom; end
                5: begin a = 7; d = ($urandom_range(0, 3) != 0) ? KEY : $urandom; end
                default: begin a = 'h40; d = $urandom; end
            endcase
            apb_write(a, d);
            for (int j = 0; j <= $urandom_range(0, 3); j++) begin
                if (j > 0) begin @(posedge PCLK); #1; end
                apb_read(0, v);
                checks++; if (v !== exp_rd(0)) begin errors++; $display("FAIL rnd_cnt i=%0d got=%h exp=%h", i, v, exp_rd(0)); end
                apb_read(3, v);
                checks++; if (v !== exp_rd(3)) begin errors++; $display("FAIL rnd_stat i=%0d got=%h exp=%h", i, v, exp_rd(3)); end
                checks++; if (IRQ !== ((m_ov && m_irqen[0]) || (m_wv && m_irqen[1])) || WDT_RST_REQ !== m_rst) begin
                    errors++; $display("FAIL rnd_out i=%0d irq=%b rst=%b exp_rst=%b", i, IRQ, WDT_RST_REQ, m_rst);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_rstreq();
        test_window();
        test_lock();
        test_collide();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/apb_wdt_gen2.md
Name: apb_wdt_gen2

Overview:
Second-generation APB watchdog with the down-counter integrated, replacing the split wrapper-plus-external-counter arrangement. Adds the following over the first generation:
- parametrised counter width
- programmable prescaler
- keyed feed and register lock
- windowed-refresh mode
- two-stage timeout: an IRQ on the first timeout, then a sticky system-reset request on the second

Sits on the APB subsystem bus alongside the other APB peripherals.

Parameters:
CNT_W, 32, counter/LOAD/WIN width (1..32); readback zero-extended to 32 bits
PRE_W, 8, prescaler width (1..16)
KEY, 32'h1ACCE551, value that must be written to FEED or LOCK to take effect

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset, asynchronous, active-low
PSEL  in  1  APB select
PADDR  in  18 [19:2]  APB word address
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  tied 1
IRQ  out  1  interrupt
WDT_RST_REQ  out  1  sticky system-reset request

Behaviour:
- One clock (PCLK); reset asynchronous active-low (PRESETn).
- Write strobe is PSEL&PWRITE&PENABLE. Reads are combinational on PADDR. Unmapped reads return 32'hDEADBEEF. PREADY=1 (zero wait states).
- Register map (word index):
  - 0x0 CNT (RO) current count
  - 0x1 LOAD (RW) reload value
  - 0x2 WIN (RW) window value
  - 0x3 STAT (RO): [0] OV, [1] RSTREQ, [2] WINVIOL, [3] LOCKED
  - 0x4 CLR (WO, reads 0): writing 1 to [0] clears OV; writing 1 to [2] clears WINVIOL
  - 0x5 CTRL (RW): [0] EN, [1] RSTEN, [2] WINEN, [8+PRE_W-1:8] PRE
  - 0x6 FEED (WO, reads 0)
  - 0x7 LOCK (WO, reads 0)
  - 0x40 IRQEN (RW): [0] OV, [1] WINVIOL
- Reset values:
  - CNT=all-ones, LOAD=0, WIN=0, CTRL=0, IRQEN=0.
  - OV, WINVIOL, RSTREQ, LOCKED=0; prescaler=0.
  - IRQ=0, WDT_RST_REQ=0.
- Lock:
  - A LOCK write with PWDATA==KEY clears LOCKED; any other value sets LOCKED.
  - While LOCKED, writes to LOAD, WIN, CTRL and IRQEN are ignored.
  - FEED, CLR and LOCK writes are never blocked.
- Prescaler:
  - While EN=1, the prescaler increments every PCLK.
  - When prescaler==PRE, a tick is produced and the prescaler returns to 0, giving a tick period of PRE+1 cycles.
  - While EN=0, the prescaler and CNT hold.
- Enable: on the CTRL write that changes EN from 0 to 1, CNT<=LOAD and prescaler<=0 on that edge.
- Count: on a tick with CNT!=0, CNT<=CNT-1.
- Timeout: on a tick with CNT==0, CNT<=LOAD.
  - If OV==0: OV<=1.
  - Else if RSTEN==1: RSTREQ<=1.
  - RSTREQ is sticky; it clears only on PRESETn.
  - WDT_RST_REQ=RSTREQ.
- Feed: a FEED write with PWDATA==KEY:
  - If WINEN==1 and CNT>WIN (too early): WINVIOL<=1, no reload. If also RSTEN==1: RSTREQ<=1.
  - Otherwise: CNT<=LOAD and prescaler<=0.
  - A FEED write with any other value is ignored.
- Simultaneous events:
  - Valid feed and timeout tick in the same cycle: the feed wins; no OV or RSTREQ change.
  - CLR write and OV/WINVIOL set in the same cycle: set wins.
  - Feed does not clear OV; software clears OV via CLR.
- Outputs:
  - IRQ=(OV&IRQEN[0])|(WINVIOL&IRQEN[1]), combinational from registered state.
- Boundary:
  - LOAD=0 gives a timeout on every tick.
  - CNT never wraps below 0; it reloads.
  - PRE=0 gives a tick every cycle.
- Reset mid-count returns every register to its reset value immediately (asynchronous).

Test Plan:
1. Reset; read CNT/STAT/CTRL -> CNT=all-ones, STAT=0, CTRL=0, IRQ=0, WDT_RST_REQ=0. Read 0x8 -> 32'hDEADBEEF.
2. LOAD=5, PRE=1, IRQEN=1, EN=1 -> CNT decrements every 2 cycles, 5..0. OV=1 and IRQ=1 exactly 12 cycles after the EN write; CNT reloads to 5.
3. From case 2 with RSTEN=1 and OV left set -> after a further 12 cycles WDT_RST_REQ=1. It stays 1 through CLR, FEED and CTRL writes until PRESETn.
4. LOAD=100, WIN=20, WINEN=1:
   - FEED KEY at CNT=50 -> WINVIOL=1, CNT unchanged.
   - FEED KEY at CNT=10 -> CNT=100.
   - FEED 32'h0 -> ignored.
5. LOCK=32'h0, then write LOAD=7 -> LOAD unchanged, STAT[3]=1. LOCK=KEY, then write LOAD=7 -> LOAD=7, STAT[3]=0.
6. LOAD=3, PRE=0: issue FEED KEY in the cycle where the CNT==0 tick occurs -> CNT=3, OV stays 0. Separately, CLR[0]=1 coincident with an OV-set tick -> OV=1.
